// File: rtl/debounce_event.sv
// debounce_event: multi-channel GPIO debouncer with press/release pulses,
// long-press detection and optional auto-repeat. All outputs are registered.
// The auto-repeat pulse output is named auto_repeat because repeat is a
// reserved word in SystemVerilog.
module debounce_event #(
  parameter int unsigned     WIDTH        = 13,
  parameter int unsigned     N            = 4,
  parameter int unsigned     RATE         = 125000,
  parameter int unsigned     HOLD_TICKS   = 1000,
  parameter int unsigned     REPEAT_TICKS = 200,
  parameter logic [WIDTH-1:0] INIT        = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] hold,
  output logic [WIDTH-1:0] held,
  output logic [WIDTH-1:0] auto_repeat
);

  localparam int unsigned PW        = $clog2(RATE);
  localparam int unsigned MAX_TICKS = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
  localparam bit          REPEAT_EN = (REPEAT_TICKS != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic [PW-1:0]    pre_cnt;
  logic             tick;
  logic             primed;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] in_sync;

  assign tick = (pre_cnt == PW'(RATE - 1));

  // Shared sample prescaler; primed marks that the first tick after reset has passed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      primed  <= 1'b0;
    end else if (tick) begin
      pre_cnt <= '0;
      primed  <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Two-flop synchroniser on the raw pad inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= INIT;
      in_sync <= INIT;
    end else begin
      sync_q  <= in;
      in_sync <= sync_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state_q;
    state_t        state_next;
    logic [N-1:0]  shift_q;
    logic [N-1:0]  shift_next;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          all_one;
    logic          all_zero;
    logic          rise_hit;
    logic          fall_hit;
    logic          count_tick;
    logic          hold_hit;
    logic          rep_hit;
    logic          out_q,  out_next;
    logic          rise_q, rise_next;
    logic          fall_q, fall_next;
    logic          hold_q, hold_next;
    logic          held_q, held_next;
    logic          rep_q,  rep_next;

    assign shift_next = {shift_q[N-2:0], in_sync[i]};
    assign all_one    = &shift_next;
    assign all_zero   = ~|shift_next;
    assign cnt_inc    = cnt_q + CW'(1);

    // Debounced-level transitions on this tick
    assign rise_hit = tick & ~out_q & all_one;
    assign fall_hit = tick &  out_q & all_zero;
    // The first tick after reset anchors the count for channels that leave reset pressed
    assign count_tick = tick & out_q & ~all_zero & primed;
    assign hold_hit   = count_tick & (state_q == PRESSED) & (cnt_inc == CW'(HOLD_TICKS));
    assign rep_hit    = count_tick & (state_q == HELD) & REPEAT_EN & (cnt_inc == CW'(REPEAT_TICKS));

    // Press-state register
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= INIT[i] ? PRESSED : IDLE;
      end else begin
        state_q <= state_next;
      end
    end

    // Press-state transitions; release wins over every other event
    always_comb begin
      state_next = state_q;
      if (fall_hit) begin
        state_next = IDLE;
      end else if (rise_hit) begin
        state_next = PRESSED;
      end else if (hold_hit) begin
        state_next = HELD;
      end
    end

    // Next values for the level, pulses, held flag and hold counter
    always_comb begin
      out_next  = out_q;
      rise_next = 1'b0;
      fall_next = 1'b0;
      hold_next = 1'b0;
      held_next = held_q;
      rep_next  = 1'b0;
      cnt_next  = cnt_q;
      if (fall_hit) begin
        out_next  = 1'b0;
        fall_next = 1'b1;
        held_next = 1'b0;
        cnt_next  = '0;
      end else if (rise_hit) begin
        out_next  = 1'b1;
        rise_next = 1'b1;
        cnt_next  = '0;
      end else if (hold_hit) begin
        hold_next = 1'b1;
        held_next = 1'b1;
        cnt_next  = '0;
      end else if (rep_hit) begin
        rep_next  = 1'b1;
        cnt_next  = '0;
      end else if (count_tick) begin
        cnt_next  = cnt_inc;
      end else if (!out_q) begin
        cnt_next  = '0;
      end
    end

    // Sample history, counter and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shift_q <= {N{INIT[i]}};
        cnt_q   <= '0;
        out_q   <= INIT[i];
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        hold_q  <= 1'b0;
        held_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        if (tick) begin
          shift_q <= shift_next;
        end
        cnt_q  <= cnt_next;
        out_q  <= out_next;
        rise_q <= rise_next;
        fall_q <= fall_next;
        hold_q <= hold_next;
        held_q <= held_next;
        rep_q  <= rep_next;
      end
    end

    assign out[i]         = out_q;
    assign rise[i]        = rise_q;
    assign fall[i]        = fall_q;
    assign hold[i]        = hold_q;
    assign held[i]        = held_q;
    assign auto_repeat[i] = rep_q;
  end

endmodule

// File: tb/tb_debounce_event.sv
// Directed bench for debounce_event: RATE=4, N=4, WIDTH=2, HOLD_TICKS=5.
// Instance a: REPEAT_TICKS=3, INIT=0; b: REPEAT_TICKS=0; c: INIT=2'b11.
module tb_debounce_event;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] in_a, in_b, in_c;
  logic [1:0] out_a, rise_a, fall_a, hold_a, held_a, rep_a;
  logic [1:0] out_b, rise_b, fall_b, hold_b, held_b, rep_b;
  logic [1:0] out_c, rise_c, fall_c, hold_c, held_c, rep_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debounce_event #(.WIDTH(2), .N(4), .RATE(4), .HOLD_TICKS(5), .REPEAT_TICKS(3), .INIT(2'b00)) dut_a (
    .clk(clk), .reset_n(reset_n), .in(in_a), .out(out_a), .rise(rise_a), .fall(fall_a),
    .hold(hold_a), .held(held_a), .auto_repeat(rep_a));

  debounce_event #(.WIDTH(2), .N(4), .RATE(4), .HOLD_TICKS(5), .REPEAT_TICKS(0), .INIT(2'b00)) dut_b (
    .clk(clk), .reset_n(reset_n), .in(in_b), .out(out_b), .rise(rise_b), .fall(fall_b),
    .hold(hold_b), .held(held_b), .auto_repeat(rep_b));

  debounce_event #(.WIDTH(2), .N(4), .RATE(4), .HOLD_TICKS(5), .REPEAT_TICKS(3), .INIT(2'b11)) dut_c (
    .clk(clk), .reset_n(reset_n), .in(in_c), .out(out_c), .rise(rise_c), .fall(fall_c),
    .hold(hold_c), .held(held_c), .auto_repeat(rep_c));

  typedef struct {
    int pre;   // posedges after reset release before the step
    int lat;   // expected posedge count from step to rise/out
  } step_vec_t;

  step_vec_t vecs[4];

  // sticky monitors for the glitch sequence
  logic       mon_en = 1'b0;
  logic [1:0] acc_out, acc_rise, acc_fall;

  always @(negedge clk) begin
    if (mon_en) begin
      acc_out  = acc_out  | out_a;
      acc_rise = acc_rise | rise_a;
      acc_fall = acc_fall | fall_a;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // waits for rise on a channel 0 of instance a (sel=0) or b (sel=1)
  task automatic wait_rise(input int sel, input string name);
    int k;
    k = -1;
    for (int j = 1; j <= 40; j++) begin
      edge_sample();
      if ((sel == 0 && rise_a[0]) || (sel == 1 && rise_b[0])) begin
        k = j;
        break;
      end
    end
    check(name, (k >= 0) ? 1 : 0, 1);
  endtask

  initial begin
    vecs[0] = '{pre: 4, lat: 16};
    vecs[1] = '{pre: 5, lat: 15};
    vecs[2] = '{pre: 6, lat: 18};
    vecs[3] = '{pre: 7, lat: 17};

    reset_n = 1'b0;
    in_a    = 2'b00;
    in_b    = 2'b00;
    in_c    = 2'b11;
    do_reset();
    #1;
    check("reset_out_a",  int'(out_a), 0);
    check("reset_pulses_a", int'({rise_a, fall_a, hold_a, rep_a}), 0);
    check("reset_held_a", int'(held_a), 0);
    check("reset_out_c",  int'(out_c), 3);
    check("reset_held_c", int'(held_c), 0);

    // clean step at each prescaler phase
    for (int v = 0; v < 4; v++) begin
      int rise_k, out_k, rise_n, ch1;
      in_a = 2'b00;
      do_reset();
      repeat (vecs[v].pre) @(posedge clk);
      @(negedge clk);
      in_a[0] = 1'b1;
      rise_k = -1; out_k = -1; rise_n = 0; ch1 = 0;
      for (int k = 1; k <= 30; k++) begin
        edge_sample();
        if (rise_a[0]) begin
          rise_n++;
          if (rise_k < 0) rise_k = k;
        end
        if (out_a[0] && out_k < 0) out_k = k;
        if (out_a[1] | rise_a[1] | fall_a[1] | hold_a[1] | held_a[1] | rep_a[1]) ch1++;
      end
      check($sformatf("step%0d_rise_lat", v), rise_k, vecs[v].lat);
      check($sformatf("step%0d_out_lat", v), out_k, vecs[v].lat);
      check($sformatf("step%0d_rise_count", v), rise_n, 1);
      check($sformatf("step%0d_ch1_static", v), ch1, 0);
      in_a = 2'b00;
    end

    // glitch rejection
    do_reset();
    acc_out = '0; acc_rise = '0; acc_fall = '0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    in_a = 2'b11;
    repeat (11) @(negedge clk);
    in_a = 2'b00;
    for (int g = 0; g < 20; g++) begin
      repeat (4) @(negedge clk);
      in_a = 2'b11;
      @(negedge clk);
      in_a = 2'b00;
    end
    repeat (30) @(negedge clk);
    mon_en = 1'b0;
    check("glitch_out",  int'(acc_out), 0);
    check("glitch_rise", int'(acc_rise), 0);
    check("glitch_fall", int'(acc_fall), 0);

    // long press with auto-repeat; release after edge +76 so the fourth zero sample lands at +92
    begin
      int hold_n, hold_r, rep_n, fall_r;
      int rep_r[8];
      int exp_rep[5];
      exp_rep = '{32, 44, 56, 68, 80};
      do_reset();
      @(negedge clk);
      in_a[0] = 1'b1;
      wait_rise(0, "long_rise_seen");
      hold_n = 0; hold_r = -1; rep_n = 0; fall_r = -1;
      for (int r = 1; r <= 130; r++) begin
        edge_sample();
        if (hold_a[0]) begin
          hold_n++;
          if (hold_r < 0) hold_r = r;
        end
        if (rep_a[0]) begin
          if (rep_n < 8) rep_r[rep_n] = r;
          rep_n++;
        end
        if (fall_a[0] && fall_r < 0) fall_r = r;
        if (r == 19) check("long_held_before", int'(held_a[0]), 0);
        if (r == 20) check("long_held_at_hold", int'(held_a[0]), 1);
        if (r == 91) check("long_held_before_fall", int'(held_a[0]), 1);
        if (r == 92) check("long_held_after_fall", int'(held_a[0]), 0);
        if (r == 76) in_a[0] = 1'b0;
      end
      check("long_hold_pos", hold_r, 20);
      check("long_hold_count", hold_n, 1);
      check("long_repeat_count", rep_n, 5);
      for (int q = 0; q < 5; q++) begin
        if (q < rep_n) check($sformatf("long_repeat%0d_pos", q), rep_r[q], exp_rep[q]);
      end
      check("long_fall_pos", fall_r, 92);
    end

    // repeat disabled
    begin
      int hold_n, hold_r, rep_n;
      do_reset();
      @(negedge clk);
      in_b[0] = 1'b1;
      wait_rise(1, "norep_rise_seen");
      hold_n = 0; hold_r = -1; rep_n = 0;
      for (int r = 1; r <= 100; r++) begin
        edge_sample();
        if (hold_b[0]) begin
          hold_n++;
          if (hold_r < 0) hold_r = r;
        end
        if (rep_b[0]) rep_n++;
      end
      check("norep_hold_pos", hold_r, 20);
      check("norep_hold_count", hold_n, 1);
      check("norep_repeat_count", rep_n, 0);
      check("norep_held", int'(held_b[0]), 1);
      in_b = 2'b00;
    end

    // release before threshold, then re-press
    begin
      int fall_r, hold_n, hold_r;
      do_reset();
      @(negedge clk);
      in_a[0] = 1'b1;
      wait_rise(0, "early_rise_seen");
      in_a[0] = 1'b0;
      fall_r = -1; hold_n = 0;
      for (int r = 1; r <= 40; r++) begin
        edge_sample();
        if (fall_a[0] && fall_r < 0) fall_r = r;
        if (hold_a[0]) hold_n++;
      end
      check("early_fall_pos", fall_r, 16);
      check("early_no_hold", hold_n, 0);
      check("early_out_low", int'(out_a[0]), 0);
      in_a[0] = 1'b1;
      wait_rise(0, "repress_rise_seen");
      hold_n = 0; hold_r = -1;
      for (int r = 1; r <= 30; r++) begin
        edge_sample();
        if (hold_a[0]) begin
          hold_n++;
          if (hold_r < 0) hold_r = r;
        end
      end
      check("repress_hold_pos", hold_r, 20);
      check("repress_hold_count", hold_n, 1);
    end

    // asynchronous reset while a repeat pulse is high
    do_reset();
    @(negedge clk);
    in_a[0] = 1'b1;
    wait_rise(0, "midreset_rise_seen");
    repeat (32) edge_sample();
    check("midreset_pre_repeat", int'(rep_a[0]), 1);
    check("midreset_pre_held", int'(held_a[0]), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_pulses", int'({rise_a, fall_a, hold_a, rep_a}), 0);
    check("midreset_held", int'(held_a), 0);
    check("midreset_out", int'(out_a), 0);
    check("midreset_out_c", int'(out_c), 3);
    in_a = 2'b00;

    // INIT=11 with inputs high: first tick edge is +4, hold expected at +24
    begin
      int rise_n, hold_j, hold_n, out_bad;
      @(negedge clk);
      reset_n = 1'b1;
      rise_n = 0; hold_j = -1; hold_n = 0; out_bad = 0;
      for (int j = 1; j <= 40; j++) begin
        edge_sample();
        if (rise_c != 2'b00) rise_n++;
        if (hold_c == 2'b11 && hold_j < 0) hold_j = j;
        if (hold_c != 2'b00) hold_n++;
        if (out_c != 2'b11) out_bad++;
        if (j == 23) check("init_held_before", int'(held_c), 0);
        if (j == 24) check("init_held_at_hold", int'(held_c), 3);
      end
      check("init_no_rise", rise_n, 0);
      check("init_hold_pos", hold_j, 24);
      check("init_hold_count", hold_n, 1);
      check("init_out_stable", out_bad, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_event.md
# debounce_event

Multi-channel debouncer and button-event generator for board GPIO inputs (push buttons, slide switches). It is the parametrised successor to the plain switch debouncer used on the board tops. Each channel gets:
- an input synchroniser
- an N-sample agreement filter clocked by a shared prescaler
- single-cycle press and release pulses
- long-press detection with optional auto-repeat

It sits between the raw pad inputs and `fpga_core`, in the 125 MHz system clock domain.

## Interface
- `WIDTH`, 13: number of independent channels.
- `N`, 4: consecutive agreeing samples required to change state (≥2).
- `RATE`, 125000: clock cycles per sample tick (≥2).
- `HOLD_TICKS`, 1000: sample ticks held high before the long-press event (≥1).
- `REPEAT_TICKS`, 200: sample ticks between auto-repeat pulses after long-press; 0 disables repeat.
- `INIT`, `{WIDTH{1'b0}}`: per-channel reset value of the debounced state.

Ports:
- `clk`  in  1  system clock. One clock only.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `in`  in  WIDTH  raw asynchronous inputs.
- `out`  out  WIDTH  debounced level.
- `rise`  out  WIDTH  1-cycle pulse on a debounced 0→1 transition.
- `fall`  out  WIDTH  1-cycle pulse on a debounced 1→0 transition.
- `hold`  out  WIDTH  1-cycle pulse when the long-press threshold is reached.
- `held`  out  WIDTH  level; high from the `hold` pulse until `out` falls.
- `repeat`  out  WIDTH  1-cycle auto-repeat pulse.

## Operation
- **Synchroniser:** 2-FF synchroniser per channel. Reset value is `INIT`. Its output is `in_sync`.
- **Prescaler:** counter 0..`RATE`-1, width `$clog2(RATE)`.
  - `tick` is asserted combinationally when the count equals `RATE`-1; the counter wraps to 0 on that edge.
  - Reset value is 0.
- **Sample shift register:** `shift[N-1:0]` per channel. Reset value is all-`INIT[i]`.
  - On `tick`: `shift_next = {shift[N-2:0], in_sync}`.
- **Debounced state** (= `out`), updated on `tick` only:
  - `shift_next` all ones → 1.
  - `shift_next` all zeros → 0.
  - Otherwise held.
- **Edge pulses:** `rise`/`fall` are registered and assert on the same edge at which `out` changes, for exactly one cycle.
- **Hold counter:** per channel, width `$clog2(max(HOLD_TICKS, REPEAT_TICKS)+1)`.
  - Cleared whenever `out` is 0, and on the tick at which `out` rises.
  - While `out`=1, incremented on each subsequent `tick`.
- **Per-channel FSM:** `IDLE` → `PRESSED` → `HELD`.
  - `IDLE`: `out`=0. On the tick where `out` rises → `PRESSED`, counter=0.
  - `PRESSED`: on the tick where counter+1 = `HOLD_TICKS`:
    - pulse `hold`, set `held`
    - clear counter
    - → `HELD`
  - `HELD`: if `REPEAT_TICKS`≠0, on the tick where counter+1 = `REPEAT_TICKS`, pulse `repeat` and clear counter.
  - Any state: on the tick where `out` falls:
    - → `IDLE`
    - clear counter and `held`
    - pulse `fall`
    - no `hold`/`repeat` pulse on that cycle
- **Reset:** a channel with `INIT[i]`=1 leaves reset in `PRESSED` with counter 0. It does not emit `rise`.
- **Channel independence:** channels share only the prescaler and never interact.
- **Reset mid-operation:** asynchronously returns every register to its reset value. Any pulses in flight are dropped.

## Timing
Reset values of the outputs:

| Output | Reset value |
|---|---|
| `out` | `INIT` |
| `held` | `INIT & 0` (all zeros) |
| `rise`, `fall`, `hold`, `repeat` | 0 |

- **Input-to-output latency** for a clean step: from 3+(N-1)·`RATE` to 2+N·`RATE` cycles, depending on the prescaler phase.
- **Glitch rejection:** any input pulse shorter than (N-1)·`RATE` cycles never changes `out`.
- **Long-press:** `hold` fires exactly `HOLD_TICKS`·`RATE` cycles after `rise`.
- **Auto-repeat:** `repeat` fires every `REPEAT_TICKS`·`RATE` cycles after `hold`.
- **Bounce near the threshold:** samples keep `out` unchanged while they disagree; the hold counter keeps counting while `out` is unchanged.
- **All outputs** are registered. There are no combinational paths from `in`.

## Test plan
Common parameters: `RATE`=4, `N`=4, `WIDTH`=2, `HOLD_TICKS`=5, `REPEAT_TICKS`=3, `INIT`=0.

1. **Clean step:** step `in[0]` 0→1 at every prescaler phase (4 runs).
   - `rise[0]` pulses once, 15..18 cycles after the step.
   - `out[0]`=1 from the same edge.
   - `in[1]` outputs stay static.
2. **Glitch rejection:** 11-cycle high glitch, then 1-cycle high glitches every 5 cycles for 100 cycles.
   - `out`, `rise`, `fall` stay 0.
3. **Long-press and repeat:** hold `in[0]` high for 80 cycles after `rise`, then release.
   - `hold` pulses 20 cycles after `rise`, and `held`=1 from then.
   - `repeat` pulses at +32, +44, +56, +68, +80 cycles after `rise` while still high.
   - After release: `fall` pulse, `held`→0, no further `repeat`.
4. **Repeat disabled (`REPEAT_TICKS`=0):** hold for 100 cycles.
   - Exactly one `hold` pulse and zero `repeat` pulses.
5. **Release before threshold:** release after 3 ticks high.
   - `fall` pulse with no `hold`.
   - Re-press restarts the count, and `hold` fires 20 cycles after the new `rise`.
6. **Reset behaviour:**
   - Assert `reset_n`=0 mid-`HELD`: all pulses and `held` clear immediately and `out`=`INIT`.
   - With `INIT`=2'b11 and `in` held high: no `rise` after reset, and `hold` fires 20 cycles after the first tick edge post-reset.
